// File: rtl/booth4_pkg.sv
// rtl/booth4_pkg.sv - shared FSM states, Booth selector codes and widths for booth4_seq_mult16
package booth4_pkg;

    localparam int OP_W   = 16;
    localparam int PP_W   = 18;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Partial-product selections produced by a radix-4 Booth code
    localparam logic [2:0] PP_ZERO   = 3'd0;
    localparam logic [2:0] PP_POS_A  = 3'd1;
    localparam logic [2:0] PP_POS_2A = 3'd2;
    localparam logic [2:0] PP_NEG_2A = 3'd3;
    localparam logic [2:0] PP_NEG_A  = 3'd4;

    // Map {b[2i+1], b[2i], b[2i-1]} onto the multiple of A it selects
    function automatic logic [2:0] booth_sel(input logic [2:0] code);
        logic [2:0] sel;
        case (code)
            3'b001, 3'b010: sel = PP_POS_A;
            3'b011:         sel = PP_POS_2A;
            3'b100:         sel = PP_NEG_2A;
            3'b101, 3'b110: sel = PP_NEG_A;
            default:        sel = PP_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth2_pp_decoder.sv
// rtl/booth2_pp_decoder.sv - radix-4 Booth partial-product decoder with inverted-sign MSB
module booth2_pp_decoder
    import booth4_pkg::*;
(
    input  logic [2:0]      code_i,
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W:0]   inversed_a_i,
    output logic [PP_W-1:0] pp_out_o
);

    logic [PP_W-1:0] pp_val;

    // Select 0, +A, +2A, -A or -2A as an 18-bit two's complement value, then flip the sign bit
    always_comb begin
        pp_val = '0;
        case (booth_sel(code_i))
            PP_POS_A:  pp_val = {{2{a_i[OP_W-1]}}, a_i};
            PP_POS_2A: pp_val = {a_i[OP_W-1], a_i, 1'b0};
            PP_NEG_A:  pp_val = {inversed_a_i[OP_W], inversed_a_i};
            PP_NEG_2A: pp_val = {inversed_a_i, 1'b0};
            default:   pp_val = '0;
        endcase
        pp_out_o = {~pp_val[PP_W-1], pp_val[PP_W-2:0]};
    end

endmodule

// File: rtl/booth4_seq_mult16.sv
// rtl/booth4_seq_mult16.sv - sequential 16x16 signed radix-4 Booth multiplier (option: BOOTH4_SEQ_EARLY_EXIT_EN)
module booth4_seq_mult16
    import booth4_pkg::*;
#(
    parameter int ITER_N = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     a_in,
    input  logic [OP_W-1:0]     b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   product
);

    state_t              state_q;
    logic [2:0]          iter_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [OP_W:0]       neg_a_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   product_q;
    logic                out_valid_q;
    logic                in_ready_q;

    logic [OP_W:0]       b_ext;
    logic [4:0]          bit_pos;
    logic [2:0]          code;
    logic [PP_W-1:0]     pp;
    logic [PROD_W-1:0]   pp_sext;
    logic [PROD_W-1:0]   acc_d;
    logic [OP_W:0]       neg_a_d;
    logic                early_exit;

    // B with the implicit B[-1]=0 appended; iteration i looks at bits [2i+2:2i]
    always_comb begin
        b_ext   = {b_q, 1'b0};
        bit_pos = {1'b0, iter_q, 1'b0};
        code    = b_ext[bit_pos +: 3];
        neg_a_d = ~{a_in[OP_W-1], a_in} + 17'd1;
    end

    booth2_pp_decoder u_pp_dec (
        .code_i       (code),
        .a_i          (a_q),
        .inversed_a_i (neg_a_q),
        .pp_out_o     (pp)
    );

    // Restore the true sign from the inverted MSB, sign-extend and weight by 4^i
    always_comb begin
        pp_sext = {{(PROD_W-PP_W+1){~pp[PP_W-1]}}, pp[PP_W-2:0]};
        acc_d   = acc_q + (pp_sext << bit_pos);
    end

`ifdef BOOTH4_SEQ_EARLY_EXIT_EN
    logic [OP_W:0] hi_bits;
    logic [OP_W:0] hi_bits_n;

    // Remaining multiplier bits all equal means every remaining Booth code is 000 or 111
    always_comb begin
        hi_bits    = b_ext >> bit_pos;
        hi_bits_n  = (~b_ext) >> bit_pos;
        early_exit = (hi_bits == '0) || (hi_bits_n == '0);
    end
`else
    // Fixed-latency build: every iteration is executed
    always_comb begin
        early_exit = 1'b0;
    end
`endif

    // Control FSM, operand capture, accumulation and registered handshake outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            iter_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            neg_a_q     <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        neg_a_q    <= neg_a_d;
                        acc_q      <= '0;
                        iter_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (early_exit) begin
                        product_q   <= acc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        acc_q  <= acc_d;
                        iter_q <= iter_q + 3'd1;
                        if (iter_q == 3'(ITER_N - 1)) begin
                            product_q   <= acc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth4_seq_mult16.sv
// tb/tb_booth4_seq_mult16.sv - self-checking bench for booth4_seq_mult16
module tb_booth4_seq_mult16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;

    int checks = 0;
    int failures = 0;

`ifdef BOOTH4_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    booth4_seq_mult16 dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Expected cycles from accept edge to out_valid
    function automatic int exp_lat(input logic [15:0] b);
        logic [16:0] be;
        logic [16:0] z;
        logic [16:0] o;
        be = {b, 1'b0};
        for (int i = 0; i < 8; i++) begin
            z = be >> (2 * i);
            o = (~be) >> (2 * i);
            if (EE && (z == 17'd0 || o == 17'd0)) return i + 1;
        end
        return 8;
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] prod, output int lat);
        int guard;
        @(negedge sys_clk);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge sys_clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        prod = product;
    endtask

    initial begin
        logic [31:0] prod;
        logic [31:0] held;
        logic signed [31:0] ref_p;
        logic [15:0] ra;
        logic [15:0] rb;
        int lat;
        int stall;

        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1]  = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[2]  = '{16'h8001, 16'h8000, 32'h3FFF8000};
        vecs[3]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[4]  = '{16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[6]  = '{16'h0000, 16'h04D2, 32'h00000000};
        vecs[7]  = '{16'h04D2, 16'h0000, 32'h00000000};
        vecs[8]  = '{16'hFFF9, 16'h0009, 32'hFFFFFFC1};
        vecs[9]  = '{16'h0064, 16'hFFFF, 32'hFFFFFF9C};
        vecs[10] = '{16'h3039, 16'hFFFE, 32'hFFFF9F8E};
        vecs[11] = '{16'h0100, 16'h0100, 32'h00010000};
        vecs[12] = '{16'h8000, 16'h0001, 32'hFFFF8000};

        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check32("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check32("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check32("reset_product", product, 32'd0);

        // Directed table with out_ready tied high
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].a, vecs[i].b, prod, lat);
            check32($sformatf("vec%0d_product", i), prod, vecs[i].exp);
            check32($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].b)));
        end
        @(posedge sys_clk);
        #1;

        // Back-pressure: hold result for 5 cycles
        out_ready = 1'b0;
        do_op(16'hFFFB, 16'h0006, prod, lat);
        check32("bp_product", prod, 32'hFFFFFFE2);
        check32("bp_latency", 32'(lat), 32'(exp_lat(16'h0006)));
        for (int c = 0; c < 5; c++) begin
            @(posedge sys_clk);
            #1;
            check32("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check32("bp_hold_product", product, 32'hFFFFFFE2);
            check32("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        check32("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check32("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of an operation (after iteration 4's edge)
        @(negedge sys_clk);
        a_in = 16'h1234;
        b_in = 16'h5678;
        in_valid = 1'b1;
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        check32("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check32("rst_mid_product", product, 32'd0);
        check32("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        do_op(16'hFFF9, 16'h0009, prod, lat);
        check32("post_rst_product", prod, 32'hFFFFFFC1);
        check32("post_rst_latency", 32'(lat), 32'(exp_lat(16'h0009)));
        @(posedge sys_clk);
        #1;

        // Random pairs with output stalls and input gaps
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ref_p = $signed(ra) * $signed(rb);
            out_ready = 1'($urandom_range(0, 1));
            do_op(ra, rb, prod, lat);
            check32("rand_product", prod, ref_p);
            check32("rand_latency", 32'(lat), 32'(exp_lat(rb)));
            held = prod;
            if (!out_ready) begin
                stall = $urandom_range(0, 3);
                for (int s = 0; s < stall; s++) begin
                    @(posedge sys_clk);
                    #1;
                    check32("rand_stall_valid", {31'd0, out_valid}, 32'd1);
                    check32("rand_stall_product", product, held);
                end
                out_ready = 1'b1;
            end
            @(posedge sys_clk);
            #1;
            check32("rand_release_valid", {31'd0, out_valid}, 32'd0);
            check32("rand_release_in_ready", {31'd0, in_ready}, 32'd1);
            repeat ($urandom_range(0, 2)) @(posedge sys_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
